// File: rtl/fpu_mul_arbiter.sv
// Round-robin arbiter sharing one combinational FP32 multiplier between two ports.
// Define FPU_MUL_ARB_STATS_EN to add the stat_ops/stat_err response counters.
module fpu_mul_arbiter #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  input  logic [1:0]  req_rm0,
  input  logic [1:0]  req_rm1,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic [1:0]  mul_round,
  output logic        mul_busy,
  input  logic [31:0] mul_result,
  input  logic        mul_error,
  input  logic        mul_overflow,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_result,
  output logic        resp_error,
  output logic        resp_overflow
`ifdef FPU_MUL_ARB_STATS_EN
  ,
  output logic [15:0] stat_ops,
  output logic [15:0] stat_err
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  state_e      state_q;
  logic        last_q;
  logic [3:0]  cnt_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [1:0]  rm_q;
  logic        id_q;
  logic [31:0] res_q;
  logic        err_q;
  logic        ovf_q;
  logic        gnt;
  logic        acc;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    gnt = (&req_valid) ? ~last_q : req_valid[1];
    req_ready = 2'b00;
    if (rst_n && state_q == IDLE && |req_valid)
      req_ready[gnt] = 1'b1;
    acc = |(req_valid & req_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      rm_q    <= 2'd0;
      id_q    <= 1'b0;
      res_q   <= 32'd0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc) begin
            id_q    <= gnt;
            last_q  <= gnt;
            a_q     <= gnt ? req_a1 : req_a0;
            b_q     <= gnt ? req_b1 : req_b0;
            rm_q    <= gnt ? req_rm1 : req_rm0;
            cnt_q   <= 4'(LAT);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == 4'd1) begin
            res_q   <= mul_result;
            err_q   <= mul_error;
            ovf_q   <= mul_overflow;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mul_a         = a_q;
  assign mul_b         = b_q;
  assign mul_round     = rm_q;
  assign mul_busy      = (state_q == BUSY);
  assign resp_valid    = (state_q == RESP);
  assign resp_id       = id_q;
  assign resp_result   = res_q;
  assign resp_error    = err_q;
  assign resp_overflow = ovf_q;

`ifdef FPU_MUL_ARB_STATS_EN
  logic [15:0] ops_q;
  logic [15:0] errc_q;
  logic        hs;

  assign hs = (state_q == RESP) && resp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_q  <= 16'd0;
      errc_q <= 16'd0;
    end else if (hs) begin
      if (ops_q != 16'hFFFF)
        ops_q <= ops_q + 16'd1;
      if ((err_q | ovf_q) && errc_q != 16'hFFFF)
        errc_q <= errc_q + 16'd1;
    end
  end

  assign stat_ops = ops_q;
  assign stat_err = errc_q;
`endif

endmodule

// File: doc/fpu_mul_arbiter.md
Name: fpu_mul_arbiter

Overview:
- Shares one combinational FP32 multiplier between two requesters.
- Round-robin arbitration; valid/ready handshake on the request side and on the response side.
- Holds the granted operands stable at the multiplier for LAT cycles, then captures result and flags.
- Sits between the FPU issue logic and the multiplier datapath; one operation in flight at a time.

Parameters:
- LAT, 2, cycles the multiplier inputs are held before the result is sampled; legal range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester request valid; bit i = requester i
- req_ready  out  2  per-requester accept; combinational
- req_a0, req_b0  in  32  requester 0 operands (IEEE-754 single)
- req_a1, req_b1  in  32  requester 1 operands
- req_rm0, req_rm1  in  2  requester round_mode
- mul_a, mul_b  out  32  operands driven to the shared multiplier
- mul_round  out  2  round_mode driven to the multiplier
- mul_busy  out  1  high while operands are held for the multiplier
- mul_result  in  32  multiplier resultMul
- mul_error  in  1  multiplier errorMul
- mul_overflow  in  1  multiplier overflowMul
- resp_valid  out  1  response valid
- resp_ready  in  1  response accept
- resp_id  out  1  requester that owns the response
- resp_result  out  32  captured result
- resp_error, resp_overflow  out  1  captured flags

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last_grant=1 (port 0 wins the first tie), cnt=0.
  - All operand/response registers cleared; resp_valid=0, mul_busy=0, req_ready=0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - grant = single valid port; if both ports are valid, grant = ~last_grant.
  - req_ready[grant]=1 only in IDLE; the other bit is 0.
  - Handshake at the edge with req_valid[i]&req_ready[i]: latch operands, round mode and id=i; set last_grant=i, cnt=LAT; go to BUSY.
  - No request valid: stay in IDLE.
- BUSY:
  - mul_busy=1; mul_a/mul_b/mul_round = latched registers, stable for the whole state.
  - Each edge: if cnt==1, capture mul_result/mul_error/mul_overflow into the resp registers and go to RESP; else cnt=cnt-1.
  - req_ready=2'b00.
- RESP:
  - resp_valid=1; resp_* held stable until the handshake.
  - resp_valid&resp_ready at an edge: go to IDLE; resp_valid drops next cycle.
  - resp_ready low: hold indefinitely.
- Latency:
  - Request accepted at edge T: BUSY for cycles T+1..T+LAT; resp_valid=1 from cycle T+LAT+1.
  - Minimum repeat interval is LAT+2 cycles. No new accept in the same cycle as a response handshake.
- Outside BUSY: mul_a/mul_b/mul_round keep their last latched values; mul_busy=0.
- Requester rules:
  - A requester must hold req_valid and its operands until accepted.
  - Operand changes while not yet granted are allowed; the value at the accept edge is used.
- Fairness: with both ports continuously valid, grants alternate 0,1,0,1…
- Flags are not reinterpreted: the NaN/Inf/overflow flags pass through exactly as sampled.
- Reset asserted mid-BUSY or mid-RESP: the operation is dropped, no response is produced, and state returns to IDLE immediately.
- resp_ready high while not in RESP: ignored.

Optional Feature:
- Macro FPU_MUL_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_ops[15:0] and stat_err[15:0], reset to 0.
  - stat_ops increments on every response handshake.
  - stat_err increments on a response handshake when resp_error|resp_overflow.
  - Both counters saturate at 16'hFFFF.
- Not defined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Single op, LAT=2: port0 sends 0x40000000×0x40400000, rm=00, accepted cycle 0 → resp_valid at cycle 3, resp_id=0, resp_result=0x40C00000, error=0, overflow=0.
- Both ports valid from reset, resp_ready=1, four requests each → grant order 0,1,0,1,0,1,0,1; resp_id matches each; req_ready is never 2'b11.
- Backpressure: resp_ready=0 for 10 cycles after resp_valid → resp fields stable, req_ready=0 throughout; release → IDLE next cycle and the pending port1 is accepted.
- NaN pass-through: port1 sends A=0x7FC00001, B=0x3F800000 → resp_result=0x7FC00001, resp_error=1, resp_overflow=0.
- Reset mid-op: rst_n low in the second BUSY cycle → resp_valid=0, mul_busy=0 immediately; after release, the first tie is granted to port 0.
- With FPU_MUL_ARB_STATS_EN: 3 ops, one of them with A=0x7F800000 → stat_ops=3, stat_err=1.
